city_arbiter: RTL and testbench
===============================

CITY_ARBITER -- requirements
Module: city_arbiter

Interface
REQ-001 Parameter: DATA_W, default 4, payload width per beat.
REQ-002 Parameter: MAX_BEATS, default 8, maximum beats per packet before forced termination.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  when high, new packets are granted; when low, no new grant starts.
REQ-006 src_valid  input  4  per-source beat valid; index 0 local_lib, 1 fire, 2 school, 3 rib_shack.
REQ-007 src_data  input  4*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 src_last  input  4  per-source final-beat flag.
REQ-009 src_ready  output  4  per-source accept; at most one bit is high in any cycle.
REQ-010 out_valid  output  1  shared channel beat valid.
REQ-011 out_data  output  DATA_W  shared channel payload.
REQ-012 out_last  output  1  shared channel final-beat flag.
REQ-013 out_src  output  2  source index of the current beat; encoding is 00 local_lib, 01 fire, 10 school, 11 rib_shack.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 overrun  output  4  sticky per-source flag; a bit sets when that source's packet is force-terminated.
REQ-016 clear_overrun  input  1  synchronous clear of all overrun bits.
REQ-017 busy  output  1  high when state is LOCKED or out_valid is high.

Function
REQ-018 A transfer on source i SHALL occur on a rising edge when src_valid[i] and src_ready[i] are both high; a transfer on the output SHALL occur when out_valid and out_ready are both high.
REQ-019 The slot is free when !out_valid || out_ready; src_ready SHALL never be high while the slot is not free.
REQ-020 The block SHALL implement a two-state FSM with states IDLE and LOCKED, and SHALL hold registers owner[1:0], last_grant[1:0] and beat_cnt.
REQ-021 In IDLE with enable high, the slot free and any src_valid high, the block SHALL grant g, the first requesting index searching from last_grant+1 mod 4 upward with wrap; src_ready[g] SHALL be high in that same cycle.
REQ-022 An IDLE grant whose beat has src_last high SHALL keep the FSM in IDLE and set last_grant=g; otherwise the FSM SHALL go to LOCKED with owner=g and beat_cnt=1.
REQ-023 In LOCKED, src_ready[owner] SHALL equal the slot-free condition, and all other src_ready bits SHALL be 0 regardless of enable.
REQ-024 A LOCKED transfer with src_last high SHALL return the FSM to IDLE with last_grant=owner; otherwise beat_cnt SHALL increment.
REQ-025 A LOCKED transfer with beat_cnt==MAX_BEATS-1 and src_last low SHALL be emitted with out_last=1, set overrun[owner], and return the FSM to IDLE with last_grant=owner; the source's next beat SHALL start a new packet.
REQ-026 An accepted beat SHALL appear on out_valid/out_data/out_last/out_src on the next cycle (1-cycle latency).
REQ-027 The block SHALL sustain one beat per cycle while out_ready is held high.
REQ-028 While out_valid is high and out_ready is low, out_data, out_last and out_src SHALL hold stable.
REQ-029 When the slot frees and no new beat is captured, out_valid SHALL drop to 0.
REQ-030 enable deasserted mid-packet SHALL NOT stall the packet; LOCKED runs to completion.
REQ-031 When clear_overrun and an overrun set occur in the same cycle, the set SHALL win for that bit.
REQ-032 Sources SHALL NOT make src_valid depend on src_ready; src_ready may depend combinationally on src_valid in IDLE.

Reset
REQ-033 While rst_n is low: state=IDLE, out_valid=0, out_data=0, out_last=0, out_src=0, last_grant=3, beat_cnt=0, owner=0, overrun=0, and src_ready=0.
REQ-034 A reset asserted mid-packet SHALL discard the partial packet; there is no recovery beat.

Structure
REQ-035 Shared package city_pkg SHALL hold the source index constants (SRC_LIB=0, SRC_FIRE=1, SRC_SCHOOL=2, SRC_RIB=3), the FSM state type and the DATA_W default.
REQ-036 The round-robin selection SHALL be a combinational sub-module city_rr_pick (inputs req[3:0] and last_grant; outputs gnt_idx and gnt_any).

Verification
REQ-037 After reset, sources 0 and 2 each send a 1-beat packet (data 4'hA and 4'h5) with out_ready=1 -> out shows A/src 00, then 5/src 10, on consecutive cycles.
REQ-038 All four sources hold a 1-beat request continuously -> grant order is 0,1,2,3,0 with no source repeating early.
REQ-039 Fire sends a 3-beat packet (1,2,3) while school requests; out_ready is low for 2 cycles at beat 2 -> beat 2 holds stable, school is not granted until after beat 3 (out_last=1, out_src=01).
REQ-040 Rib_shack sends 10 beats with src_last low -> beat 8 carries out_last=1, overrun[3]=1, and beats 9-10 arbitrate as a new packet; clear_overrun then clears overrun[3] to 0.
REQ-041 enable drops after beat 1 of a 2-beat packet -> beat 2 still completes, then no further grants occur while enable=0.
REQ-042 rst_n is pulsed low mid-packet -> all outputs return to reset values immediately, and the next grant goes to index 0.

Source files
------------

// File: rtl/city_pkg.sv
// Shared definitions for the city arbiter: source indices, FSM state type
// and the default payload width.
package city_pkg;

    localparam int NUM_SRC    = 4;
    localparam int DEF_DATA_W = 4;

    localparam logic [1:0] SRC_LIB    = 2'd0;
    localparam logic [1:0] SRC_FIRE   = 2'd1;
    localparam logic [1:0] SRC_SCHOOL = 2'd2;
    localparam logic [1:0] SRC_RIB    = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/city_rr_pick.sv
// Round-robin picker: first requester searching upward from last_grant+1,
// wrapping modulo four.
module city_rr_pick
    import city_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [1:0]         gnt_idx,
    output logic               gnt_any
);

    logic [1:0] idx;

    always_comb begin
        gnt_idx = last_grant;
        gnt_any = 1'b0;
        idx     = last_grant;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = last_grant + 2'(k);
            if (!gnt_any && req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/city_arbiter.sv
// Four-source packet arbiter onto one registered output channel, with
// round-robin packet grants and forced termination of over-long packets.
module city_arbiter
    import city_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BEATS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [1:0]                  out_src,
    input  logic                        out_ready,
    output logic [NUM_SRC-1:0]          overrun,
    input  logic                        clear_overrun,
    output logic                        busy
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t             state, state_n;
    logic [1:0]         owner, owner_n;
    logic [1:0]         last_grant, last_grant_n;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
    logic               out_valid_n, out_last_n;
    logic [DATA_W-1:0]  out_data_n;
    logic [1:0]         out_src_n;
    logic [NUM_SRC-1:0] overrun_n, ready_c;
    logic [1:0]         gnt_idx, sel;
    logic               gnt_any, slot_free, take, forced;

    city_rr_pick u_pick (
        .req        (src_valid),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        beat_cnt_n   = beat_cnt;
        ready_c      = '0;
        sel          = owner;
        take         = 1'b0;
        forced       = 1'b0;

        case (state)
            IDLE: begin
                if (enable && slot_free && gnt_any) begin
                    sel              = gnt_idx;
                    ready_c[gnt_idx] = 1'b1;
                    take             = 1'b1;
                    if (src_last[gnt_idx]) begin
                        last_grant_n = gnt_idx;
                    end else begin
                        state_n    = LOCKED;
                        owner_n    = gnt_idx;
                        beat_cnt_n = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                ready_c[owner] = slot_free;
                if (slot_free && src_valid[owner]) begin
                    take = 1'b1;
                    if (src_last[owner] || beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        forced       = !src_last[owner];
                        state_n      = IDLE;
                        last_grant_n = owner;
                        beat_cnt_n   = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_last_n  = out_last;
        out_src_n   = out_src;
        if (take) begin
            out_valid_n = 1'b1;
            out_data_n  = src_data[int'(sel)*DATA_W +: DATA_W];
            out_last_n  = src_last[sel] || forced;
            out_src_n   = sel;
        end else if (out_ready) begin
            out_valid_n = 1'b0;
        end

        // A same-cycle set overrides the clear for that bit.
        overrun_n = clear_overrun ? '0 : overrun;
        if (forced) overrun_n[owner] = 1'b1;
    end

    // Grants are combinational, so they are masked while reset is held.
    assign src_ready = rst_n ? ready_c : '0;
    assign busy      = (state == LOCKED) || out_valid;

    // NOTE: all state here is control or a few output flops, so each one has an async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= SRC_LIB;
            last_grant <= SRC_RIB;
            beat_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_src    <= '0;
            overrun    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            beat_cnt   <= beat_cnt_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_last   <= out_last_n;
            out_src    <= out_src_n;
            overrun    <= overrun_n;
        end
    end

endmodule

// File: tb/tb_city_arbiter.sv
// Self-checking bench for city_arbiter: packet-level model compared every
// cycle, plus directed scenarios with literal expected beat sequences.
module tb_city_arbiter;
    import city_pkg::*;

    localparam int DW = 4;
    localparam int MB = 8;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [3:0]      src_valid;
    logic [4*DW-1:0] src_data;
    logic [3:0]      src_last;
    logic [3:0]      src_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
    logic            out_ready;
    logic [3:0]      overrun;
    logic            clear_overrun;
    logic            busy;

    city_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_src       (out_src),
        .out_ready     (out_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source beat queues ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t      mem [4][16];
    int         head [4];
    int         tail [4];
    logic [3:0] fire_m;

    task automatic push(input int s, input int d, input int l);
        mem[s][tail[s]].d = DW'(d);
        mem[s][tail[s]].l = (l != 0);
        tail[s]++;
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            src_valid[i]          = head[i] < tail[i];
            src_data[i*DW +: DW]  = src_valid[i] ? mem[i][head[i]].d : '0;
            src_last[i]           = src_valid[i] ? mem[i][head[i]].l : 1'b0;
        end
    endtask

    always @(negedge clk) fire_m <= rst_n ? (src_valid & src_ready) : 4'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (rst_n && fire_m[i]) head[i]++;
        apply();
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        int            owner;   // -1 when no packet is open
        int            beats;   // beats already sent in the open packet
        int            lg;      // source that most recently finished a packet
        logic [3:0]    ovr;
        logic          ov;
        logic [DW-1:0] od;
        logic          ol;
        logic [1:0]    os;
    } mstate_t;

    mstate_t m;

    function automatic logic [3:0] exp_ready(input mstate_t s);
        logic [3:0] r;
        logic       slot;
        r    = 4'b0;
        slot = !s.ov || out_ready;
        if (!rst_n || !slot) return r;
        if (s.owner >= 0) begin
            r[s.owner] = 1'b1;
        end else if (enable) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (s.lg + k) % 4;
                if (r == 4'b0 && src_valid[c]) r[c] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s);
        mstate_t    n;
        logic [3:0] r;
        int         who;
        n   = s;
        r   = exp_ready(s);
        who = -1;
        for (int i = 0; i < 4; i++)
            if (r[i] && src_valid[i]) who = i;
        n.ovr = clear_overrun ? 4'b0 : s.ovr;
        if (who >= 0) begin
            int   beats;
            logic lst;
            logic forced;
            beats  = (s.owner >= 0) ? s.beats + 1 : 1;
            lst    = src_last[who];
            forced = !lst && (beats == MB);
            n.ov   = 1'b1;
            n.od   = src_data[who*DW +: DW];
            n.ol   = lst || forced;
            n.os   = 2'(who);
            if (lst || forced) begin
                n.owner = -1;
                n.beats = 0;
                n.lg    = who;
            end else begin
                n.owner = who;
                n.beats = beats;
            end
            if (forced) n.ovr[who] = 1'b1;
        end else if (out_ready) begin
            n.ov = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, beats: 0, lg: 3, ovr: 4'b0, ov: 1'b0, od: '0, ol: 1'b0, os: 2'b0};
        else        m <= model_step(m);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_src_ready", src_ready, exp_ready(m));
        check("cyc_out_valid", out_valid, m.ov);
        check("cyc_overrun",   overrun,   m.ovr);
        check("cyc_busy",      busy,      (m.owner >= 0) || m.ov);
        if (m.ov) begin
            check("cyc_out_data", out_data, m.od);
            check("cyc_out_last", out_last, m.ol);
            check("cyc_out_src",  out_src,  m.os);
        end
    end

    // ---------------- output transfer log ----------------
    typedef struct {
        int src;
        int data;
        int last;
        int cyc;
    } ent_t;

    ent_t log_q[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            log_q.push_back('{src: int'(out_src), data: int'(out_data), last: int'(out_last), cyc: cyc});

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, (log_q.size() >= n), 1);
    endtask

    task automatic check_ent(input string name, input int idx, input logic [1:0] s, input int d, input int l);
        if (idx < log_q.size()) begin
            check({name, "_src"},  log_q[idx].src,  s);
            check({name, "_data"}, log_q[idx].data, d);
            check({name, "_last"}, log_q[idx].last, l);
        end else begin
            check({name, "_present"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b1;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        apply();
        repeat (2) tick();
        rst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Reset values of the outputs.
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun",   overrun,   0);
        check("rst_busy",      busy,      0);

        // Two single-beat packets back to back.
        push(0, 'hA, 1);
        push(2, 'h5, 1);
        apply();
        run_until(2, 20, "t1_done");
        check_ent("t1_b0", 0, SRC_LIB,    'hA, 1);
        check_ent("t1_b1", 1, SRC_SCHOOL, 'h5, 1);
        if (log_q.size() >= 2) check("t1_consecutive", log_q[1].cyc - log_q[0].cyc, 1);

        // All sources requesting: strict rotation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, i + 1, 1);
            push(i, i + 8, 1);
        end
        apply();
        run_until(8, 40, "t2_done");
        for (int j = 0; j < 8; j++)
            check_ent("t2_rot", j, 2'(j % 4), (j < 4) ? (j + 1) : (j % 4 + 8), 1);

        // Fire 3-beat packet with a back-pressure stall on beat 2.
        do_reset();
        push(1, 1, 0);
        push(1, 2, 0);
        push(1, 3, 1);
        push(2, 7, 1);
        apply();
        begin
            int k;
            k = 0;
            while (!(out_valid && out_data == 4'd2) && k < 20) begin
                tick();
                k++;
            end
        end
        check("t3_beat2_seen", (out_valid && out_data == 4'd2), 1);
        out_ready = 1'b0;
        repeat (2) begin
            tick();
            check("t3_hold_data",  out_data,  2);
            check("t3_hold_src",   out_src,   SRC_FIRE);
            check("t3_hold_valid", out_valid, 1);
            check("t3_no_ready",   src_ready, 0);
        end
        out_ready = 1'b1;
        run_until(4, 20, "t3_done");
        check_ent("t3_b1", 0, SRC_FIRE,   1, 0);
        check_ent("t3_b2", 1, SRC_FIRE,   2, 0);
        check_ent("t3_b3", 2, SRC_FIRE,   3, 1);
        check_ent("t3_sc", 3, SRC_SCHOOL, 7, 1);

        // Rib_shack over-long packet gets force-terminated at beat 8.
        do_reset();
        for (int b = 1; b <= 10; b++) push(3, b, 0);
        push(3, 11, 1);
        apply();
        run_until(11, 40, "t4_done");
        for (int b = 1; b <= 11; b++)
            check_ent("t4_beat", b - 1, SRC_RIB, b, (b == 8 || b == 11) ? 1 : 0);
        check("t4_overrun_set", overrun, 4'b1000);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("t4_overrun_clr", overrun, 4'b0000);

        // enable dropped mid-packet: packet completes, no new grants.
        do_reset();
        push(0, 4, 0);
        push(0, 6, 1);
        push(1, 9, 1);
        apply();
        tick();
        enable = 1'b0;
        repeat (6) tick();
        check("t5_count", log_q.size(), 2);
        check_ent("t5_b1", 0, SRC_LIB, 4, 0);
        check_ent("t5_b2", 1, SRC_LIB, 6, 1);
        check("t5_no_ready", src_ready, 0);
        enable = 1'b1;
        run_until(3, 10, "t5_resume");
        check_ent("t5_fire", 2, SRC_FIRE, 9, 1);

        // Reset mid-packet discards it; next grant goes to index 0.
        do_reset();
        push(2, 1, 0);
        push(2, 2, 0);
        push(2, 3, 1);
        apply();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        apply();
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data",  out_data,  0);
        check("t6_out_last",  out_last,  0);
        check("t6_out_src",   out_src,   0);
        check("t6_src_ready", src_ready, 0);
        check("t6_busy",      busy,      0);
        check("t6_overrun",   overrun,   0);
        tick();
        rst_n = 1'b1;
        log_q.delete();
        push(0, 'hC, 1);
        push(1, 'hD, 1);
        push(2, 'hE, 1);
        apply();
        run_until(3, 20, "t6_done");
        check_ent("t6_g0", 0, SRC_LIB,    'hC, 1);
        check_ent("t6_g1", 1, SRC_FIRE,   'hD, 1);
        check_ent("t6_g2", 2, SRC_SCHOOL, 'hE, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
